// File: rtl/send_pkt_mux_n_pkg.sv
// =============================================================================
// Module      : send_pkt_mux_n_pkg
// Description : Shared TCP slow-path transmit types and mux arbitration modes.
// Revision    : 1.0
// =============================================================================
`timescale 1ns/1ps
`default_nettype none

package send_pkt_mux_n_pkg;

    typedef struct packed {
        logic [7:0]  flags;
        logic [15:0] payload_len;
        logic [31:0] seq_num;
        logic [7:0]  flowid;
    } send_pkt_struct;

    localparam int SEND_PKT_STRUCT_W = $bits(send_pkt_struct);

    localparam int ARB_RR    = 0;
    localparam int ARB_FIXED = 1;

endpackage

`default_nettype wire

// File: rtl/send_pkt_mux_arb.sv
// =============================================================================
// Module      : send_pkt_mux_arb
// Description : Round-robin / fixed-priority grant generator with last-grant pointer.
// Revision    : 1.0
// =============================================================================
`timescale 1ns/1ps
`default_nettype none

module send_pkt_mux_arb
    import send_pkt_mux_n_pkg::*;
#(
    parameter int NUM_SRCS = 4,
    parameter int ARB_MODE = ARB_RR,
    parameter int SRC_W    = $clog2(NUM_SRCS)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [NUM_SRCS-1:0] reqs,
    input  logic                space,
    output logic [NUM_SRCS-1:0] grant,
    output logic [SRC_W-1:0]    grant_idx,
    output logic                grant_val
);

    logic [SRC_W-1:0] last_q;
    logic [SRC_W-1:0] last_d;
    logic [SRC_W-1:0] cand_idx;
    logic             found;
    int               cand;

    // Search starts one past the last accepted source; fixed mode always starts at 0.
    always_comb begin
        found     = 1'b0;
        grant_idx = '0;
        cand      = 0;
        cand_idx  = '0;
        for (int off = 0; off < NUM_SRCS; off++) begin
            if (ARB_MODE == ARB_FIXED) begin
                cand = off;
            end else begin
                cand = (int'(last_q) + off + 1) % NUM_SRCS;
            end
            cand_idx = SRC_W'(cand);
            if (!found && reqs[cand_idx]) begin
                found     = 1'b1;
                grant_idx = cand_idx;
            end
        end
    end

    always_comb begin
        grant_val = found && space;
        grant     = grant_val ? (NUM_SRCS'(1) << grant_idx) : '0;
        last_d    = grant_val ? grant_idx : last_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            last_q <= SRC_W'(NUM_SRCS - 1);
        end else begin
            last_q <= last_d;
        end
    end

endmodule

`default_nettype wire

// File: rtl/send_pkt_mux_n.sv
// =============================================================================
// Module      : send_pkt_mux_n
// Description : N-source send_pkt_struct arbiter/mux with a 2-entry output buffer.
// Revision    : 1.0
// =============================================================================
`timescale 1ns/1ps
`default_nettype none

module send_pkt_mux_n
    import send_pkt_mux_n_pkg::*;
#(
    parameter int NUM_SRCS = 4,
    parameter int DATA_W   = SEND_PKT_STRUCT_W,
    parameter int ARB_MODE = ARB_RR,
    parameter int SRC_W    = $clog2(NUM_SRCS)
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [NUM_SRCS-1:0]        srcs_mux_val,
    input  logic [NUM_SRCS*DATA_W-1:0] srcs_mux_data,
    output logic [NUM_SRCS-1:0]        mux_srcs_rdy,
    output logic                       mux_dst_val,
    output logic [DATA_W-1:0]          mux_dst_data,
    output logic [SRC_W-1:0]           mux_dst_src,
    input  logic                       dst_mux_rdy
);

    logic [NUM_SRCS-1:0] grant;
    logic [SRC_W-1:0]    grant_idx;
    logic                grant_val;
    logic                space;
    logic                push;
    logic                pop;
    logic [DATA_W-1:0]   sel_data;
    logic [DATA_W-1:0]   or_chain [NUM_SRCS+1];

    logic [DATA_W-1:0]   fifo_data_q [2];
    logic [DATA_W-1:0]   fifo_data_d [2];
    logic [SRC_W-1:0]    fifo_src_q  [2];
    logic [SRC_W-1:0]    fifo_src_d  [2];
    logic                head_q, head_d;
    logic                tail_q, tail_d;
    logic [1:0]          count_q, count_d;

    // Ready depends only on registered occupancy, keeping dst_mux_rdy off the rdy path.
    assign space = (count_q != 2'd2) && !rst;

    send_pkt_mux_arb #(
        .NUM_SRCS (NUM_SRCS),
        .ARB_MODE (ARB_MODE),
        .SRC_W    (SRC_W)
    ) u_arb (
        .clk       (clk),
        .rst       (rst),
        .reqs      (srcs_mux_val),
        .space     (space),
        .grant     (grant),
        .grant_idx (grant_idx),
        .grant_val (grant_val)
    );

    assign or_chain[0] = '0;
    for (genvar i = 0; i < NUM_SRCS; i++) begin : g_mux
        assign or_chain[i+1] = or_chain[i]
                             | (srcs_mux_data[i*DATA_W +: DATA_W] & {DATA_W{grant[i]}});
    end
    assign sel_data = or_chain[NUM_SRCS];

    assign mux_srcs_rdy = grant;
    assign mux_dst_val  = (count_q != 2'd0) && !rst;
    assign mux_dst_data = fifo_data_q[head_q];
    assign mux_dst_src  = fifo_src_q[head_q];
    assign push         = grant_val;
    assign pop          = mux_dst_val && dst_mux_rdy;

    always_comb begin
        fifo_data_d = fifo_data_q;
        fifo_src_d  = fifo_src_q;
        head_d      = head_q;
        tail_d      = tail_q;
        count_d     = count_q;
        if (push) begin
            fifo_data_d[tail_q] = sel_data;
            fifo_src_d[tail_q]  = grant_idx;
            tail_d              = ~tail_q;
        end
        if (pop) begin
            head_d = ~head_q;
        end
        case ({push, pop})
            2'b10:   count_d = count_q + 2'd1;
            2'b01:   count_d = count_q - 2'd1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            head_q  <= 1'b0;
            tail_q  <= 1'b0;
            count_q <= 2'd0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        fifo_data_q <= fifo_data_d;
        fifo_src_q  <= fifo_src_d;
    end

endmodule

`default_nettype wire

// File: tb/tb_send_pkt_mux_n.sv
// =============================================================================
// Module      : tb_send_pkt_mux_n
// Description : Self-checking bench: round-robin and fixed-priority instances
//               against a queue-based reference model, plus directed scenarios.
// Revision    : 1.0
// =============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_send_pkt_mux_n;
    import send_pkt_mux_n_pkg::*;

    localparam int N  = 4;
    localparam int DW = SEND_PKT_STRUCT_W;
    localparam int SW = $clog2(N);

    typedef struct packed {
        logic [DW-1:0] d;
        logic [SW-1:0] s;
    } beat_t;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic [N-1:0]    val   [2];
    logic [N*DW-1:0] data  [2];
    logic [N-1:0]    rdy   [2];
    logic            oval  [2];
    logic [DW-1:0]   odata [2];
    logic [SW-1:0]   osrc  [2];
    logic            drdy  [2];
    logic [N-1:0]    acc   [2];

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    for (genvar l = 0; l < 2; l++) begin : g_lane
        send_pkt_mux_n #(
            .NUM_SRCS (N),
            .DATA_W   (DW),
            .ARB_MODE (l)
        ) u_dut (
            .clk           (clk),
            .rst           (rst),
            .srcs_mux_val  (val[l]),
            .srcs_mux_data (data[l]),
            .mux_srcs_rdy  (rdy[l]),
            .mux_dst_val   (oval[l]),
            .mux_dst_data  (odata[l]),
            .mux_dst_src   (osrc[l]),
            .dst_mux_rdy   (drdy[l])
        );

        beat_t mq[$];
        int    last = N - 1;

        // Reference: queue of accepted beats in acceptance order, pointer as an integer.
        always @(negedge clk) begin : p_model
            logic [N-1:0] er;
            logic         ev;
            int           pick;
            int           c;
            beat_t        b;
            er   = '0;
            pick = -1;
            if (!rst && mq.size() < 2) begin
                for (int k = 0; k < N; k++) begin
                    c = (l == ARB_FIXED) ? k : (last + 1 + k) % N;
                    if (pick < 0 && val[l][c]) pick = c;
                end
            end
            if (pick >= 0) er[pick] = 1'b1;
            ev = !rst && (mq.size() > 0);
            chk($sformatf("L%0d rdy", l), 64'(rdy[l]), 64'(er));
            chk($sformatf("L%0d val", l), 64'(oval[l]), 64'(ev));
            if (ev) begin
                chk($sformatf("L%0d data", l), 64'(odata[l]), 64'(mq[0].d));
                chk($sformatf("L%0d src", l), 64'(osrc[l]), 64'(mq[0].s));
            end
            acc[l] = er;
            if (rst) begin
                mq.delete();
                last = N - 1;
            end else begin
                if (ev && drdy[l]) void'(mq.pop_front());
                if (pick >= 0) begin
                    b.d = data[l][pick*DW +: DW];
                    b.s = SW'(pick);
                    mq.push_back(b);
                    last = pick;
                end
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic at_neg();
        @(negedge clk);
    endtask

    task automatic setv(input logic [N-1:0] v);
        for (int l = 0; l < 2; l++) val[l] = v;
    endtask

    task automatic setd(input int src, input logic [DW-1:0] d);
        for (int l = 0; l < 2; l++) data[l][src*DW +: DW] = d;
    endtask

    task automatic setr(input logic r);
        for (int l = 0; l < 2; l++) drdy[l] = r;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        setv('0);
        cyc();
        rst = 1'b0;
    endtask

    initial begin
        for (int l = 0; l < 2; l++) begin
            val[l]  = '0;
            data[l] = '0;
            drdy[l] = 1'b1;
            acc[l]  = '0;
        end
        for (int i = 0; i < N; i++) setd(i, DW'(32'h10 + i));
        repeat (3) cyc();
        at_neg();
        chk("reset val", 64'(oval[0]), 64'd0);
        chk("reset rdy", 64'(rdy[0]), 64'd0);
        cyc();
        rst = 1'b0;

        // Single source: src2 with data 0xA5
        setd(2, DW'(8'hA5));
        setv(4'b0100);
        at_neg();
        chk("single rdy", 64'(rdy[0]), 64'h4);
        cyc();
        setv('0);
        at_neg();
        chk("single val", 64'(oval[0]), 64'd1);
        chk("single data", 64'(odata[0]), 64'hA5);
        chk("single src", 64'(osrc[0]), 64'd2);
        cyc();
        at_neg();
        chk("single idle", 64'(oval[0]), 64'd0);
        cyc();
        setd(2, DW'(32'h12));

        // Round-robin fairness
        do_reset();
        setv(4'hF);
        for (int k = 0; k < 8; k++) begin
            at_neg();
            chk("rr rdy", 64'(rdy[0]), 64'(1 << (k % 4)));
            if (k >= 1) begin
                chk("rr val", 64'(oval[0]), 64'd1);
                chk("rr src", 64'(osrc[0]), 64'((k - 1) % 4));
            end
            cyc();
        end

        // Backpressure: two absorbed, then release
        do_reset();
        setr(1'b0);
        setv(4'hF);
        for (int k = 0; k < 6; k++) begin
            at_neg();
            chk("bp rdy", 64'(rdy[0]), (k == 0) ? 64'h1 : (k == 1) ? 64'h2 : 64'h0);
            if (k >= 1) chk("bp head", 64'(osrc[0]), 64'd0);
            cyc();
        end
        setr(1'b1);
        at_neg();
        chk("bp rel src0", 64'(osrc[0]), 64'd0);
        chk("bp rel rdy0", 64'(rdy[0]), 64'h0);
        cyc();
        at_neg();
        chk("bp rel src1", 64'(osrc[0]), 64'd1);
        chk("bp rel rdy1", 64'(rdy[0]), 64'h4);
        cyc();
        at_neg();
        chk("bp rel src2", 64'(osrc[0]), 64'd2);
        chk("bp rel rdy2", 64'(rdy[0]), 64'h8);
        cyc();

        // Pointer hold while full
        do_reset();
        setr(1'b0);
        setv(4'b0001);
        at_neg();
        chk("hold acc0a", 64'(rdy[0]), 64'h1);
        cyc();
        at_neg();
        chk("hold acc0b", 64'(rdy[0]), 64'h1);
        cyc();
        setv(4'b1010);
        for (int k = 0; k < 3; k++) begin
            at_neg();
            chk("hold full rdy", 64'(rdy[0]), 64'h0);
            cyc();
        end
        setr(1'b1);
        at_neg();
        chk("hold pop rdy", 64'(rdy[0]), 64'h0);
        cyc();
        at_neg();
        chk("hold next grant", 64'(rdy[0]), 64'h2);
        cyc();

        // Reset with two entries buffered
        do_reset();
        setr(1'b0);
        setv(4'hF);
        at_neg();
        cyc();
        at_neg();
        cyc();
        setv(4'b0110);
        rst = 1'b1;
        at_neg();
        chk("mid rst val", 64'(oval[0]), 64'd0);
        chk("mid rst rdy", 64'(rdy[0]), 64'd0);
        cyc();
        rst = 1'b0;
        at_neg();
        chk("post rst val", 64'(oval[0]), 64'd0);
        chk("post rst grant", 64'(rdy[0]), 64'h2);
        cyc();
        at_neg();
        chk("post rst src", 64'(osrc[0]), 64'd1);
        cyc();

        // Fixed priority on lane 1
        do_reset();
        setr(1'b1);
        setv(4'b1010);
        for (int k = 0; k < 4; k++) begin
            at_neg();
            chk("fix rdy", 64'(rdy[1]), 64'h2);
            if (k >= 1) chk("fix src", 64'(osrc[1]), 64'd1);
            cyc();
        end
        setv(4'b1000);
        at_neg();
        chk("fix rdy3", 64'(rdy[1]), 64'h8);
        cyc();
        at_neg();
        chk("fix src3", 64'(osrc[1]), 64'd3);
        cyc();

        // Randomized traffic; sources hold until the model says they were accepted
        for (int c = 0; c < 3000; c++) begin
            rst = ($urandom_range(0, 299) == 0);
            for (int l = 0; l < 2; l++) begin
                drdy[l] = ($urandom_range(0, 9) < 7);
                for (int i = 0; i < N; i++) begin
                    if (!(val[l][i] && !acc[l][i])) begin
                        val[l][i]              = 1'($urandom_range(0, 1));
                        data[l][i*DW +: DW]    = DW'({$urandom, $urandom});
                    end
                end
            end
            cyc();
        end
        rst = 1'b0;
        cyc();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
